// File: rtl/score_display_if.sv
// Signal bundle between the score tracker side and the score display block.
// The master drives scores and the game-over level; the slave returns digits and segment drive.
interface score_display_if;
  logic [6:0] currScore;
  logic [6:0] highScore;
  logic       isGameComplete;
  logic [3:0] currTens;
  logic [3:0] currOnes;
  logic [3:0] highTens;
  logic [3:0] highOnes;
  logic       busy;
  logic       updated;
  logic [6:0] seg;
  logic [3:0] digitSel;

  modport master (
    output currScore, highScore, isGameComplete,
    input  currTens, currOnes, highTens, highOnes, busy, updated, seg, digitSel
  );

  modport slave (
    input  currScore, highScore, isGameComplete,
    output currTens, currOnes, highTens, highOnes, busy, updated, seg, digitSel
  );
endinterface

// File: rtl/score_display.sv
// Converts two 7-bit scores to BCD with a sequential double-dabble, then drives a
// four-digit multiplexed seven-segment display with leading-zero blanking and game-over blink.
module score_display #(
  parameter int unsigned SCAN_DIV  = 1024,
  parameter int unsigned BLINK_DIV = 16384
) (
  input logic            clk,
  input logic            rst,
  score_display_if.slave bus
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  function automatic logic [6:0] clamp99(logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] add3(logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  state_e     state;
  logic [6:0] shadow_curr, shadow_high;
  logic [6:0] op_curr, op_high;
  logic [7:0] bcd_curr, bcd_high;
  logic [7:0] adj_curr, adj_high;
  logic [2:0] shift_cnt;
  logic [3:0] curr_tens, curr_ones, high_tens, high_ones;
  logic       busy, updated;

  logic [3:0] curr_tens_d, curr_ones_d, high_tens_d, high_ones_d;

  logic [ScanW-1:0]  scan_cnt;
  logic [BlinkW-1:0] blink_cnt;
  logic [1:0]        sel_idx, sel_idx_d;
  logic              blink_on, blink_on_d;
  logic [3:0]        digit_sel;
  logic [6:0]        seg, seg_d;
  logic [3:0]        disp_digit;
  logic              disp_blank;
  logic              inputs_changed;

  assign adj_curr       = add3(bcd_curr);
  assign adj_high       = add3(bcd_high);
  assign inputs_changed = (bus.currScore != shadow_curr) || (bus.highScore != shadow_high);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      shadow_curr <= '0;
      shadow_high <= '0;
      op_curr     <= '0;
      op_high     <= '0;
      bcd_curr    <= '0;
      bcd_high    <= '0;
      shift_cnt   <= '0;
      curr_tens   <= '0;
      curr_ones   <= '0;
      high_tens   <= '0;
      high_ones   <= '0;
      busy        <= 1'b0;
      updated     <= 1'b0;
    end else begin
      updated <= 1'b0;
      case (state)
        StIdle: begin
          if (inputs_changed) begin
            shadow_curr <= bus.currScore;
            shadow_high <= bus.highScore;
            op_curr     <= clamp99(bus.currScore);
            op_high     <= clamp99(bus.highScore);
            bcd_curr    <= '0;
            bcd_high    <= '0;
            shift_cnt   <= '0;
            busy        <= 1'b1;
            state       <= StShift;
          end
        end
        StShift: begin
          // Adjust-then-shift; the operand's MSB slides into the BCD LSB.
          {bcd_curr, op_curr} <= {adj_curr, op_curr} << 1;
          {bcd_high, op_high} <= {adj_high, op_high} << 1;
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd6) state <= StDone;
        end
        StDone: begin
          curr_tens <= curr_tens_d;
          curr_ones <= curr_ones_d;
          high_tens <= high_tens_d;
          high_ones <= high_ones_d;
          updated   <= 1'b1;
          busy      <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Segment drive is computed from next-cycle digits so seg never lags a digit update.
  always_comb begin
    curr_tens_d = curr_tens;
    curr_ones_d = curr_ones;
    high_tens_d = high_tens;
    high_ones_d = high_ones;
    if (state == StDone) begin
      curr_tens_d = bcd_curr[7:4];
      curr_ones_d = bcd_curr[3:0];
      high_tens_d = bcd_high[7:4];
      high_ones_d = bcd_high[3:0];
    end

    sel_idx_d = (scan_cnt == ScanLast) ? sel_idx + 2'd1 : sel_idx;

    if (!bus.isGameComplete)       blink_on_d = 1'b1;
    else if (blink_cnt == BlinkLast) blink_on_d = ~blink_on;
    else                           blink_on_d = blink_on;

    disp_digit = curr_ones_d;
    disp_blank = 1'b0;
    case (sel_idx_d)
      2'd0: begin
        disp_digit = curr_ones_d;
        disp_blank = ~blink_on_d;
      end
      2'd1: begin
        disp_digit = curr_tens_d;
        disp_blank = ~blink_on_d || (curr_tens_d == 4'd0);
      end
      2'd2: begin
        disp_digit = high_ones_d;
        disp_blank = 1'b0;
      end
      default: begin
        disp_digit = high_tens_d;
        disp_blank = (high_tens_d == 4'd0);
      end
    endcase
    seg_d = disp_blank ? 7'h00 : seg_of(disp_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      sel_idx   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      digit_sel <= 4'b0001;
      seg       <= 7'h3F;
    end else begin
      scan_cnt <= (scan_cnt == ScanLast) ? '0 : scan_cnt + ScanW'(1);
      sel_idx  <= sel_idx_d;
      if (!bus.isGameComplete || blink_cnt == BlinkLast) blink_cnt <= '0;
      else                                              blink_cnt <= blink_cnt + BlinkW'(1);
      blink_on  <= blink_on_d;
      digit_sel <= 4'b0001 << sel_idx_d;
      seg       <= seg_d;
    end
  end

  assign bus.currTens = curr_tens;
  assign bus.currOnes = curr_ones;
  assign bus.highTens = high_tens;
  assign bus.highOnes = high_ones;
  assign bus.busy     = busy;
  assign bus.updated  = updated;
  assign bus.seg      = seg;
  assign bus.digitSel = digit_sel;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: two instances with different scan/blink dividers, a behavioural
// model of conversion and display, and a scoreboard of expected digit updates.
module tb_score_display;

  localparam int unsigned ScanA  = 1;
  localparam int unsigned BlinkA = 8;
  localparam int unsigned ScanB  = 3;
  localparam int unsigned BlinkB = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cs  = '0;
  logic [6:0] hs  = '0;
  logic       igc = 1'b0;

  always #5 clk = ~clk;

  score_display_if bus_a ();
  score_display_if bus_b ();

  assign bus_a.currScore      = cs;
  assign bus_a.highScore      = hs;
  assign bus_a.isGameComplete = igc;
  assign bus_b.currScore      = cs;
  assign bus_b.highScore      = hs;
  assign bus_b.isGameComplete = igc;

  score_display #(.SCAN_DIV(ScanA), .BLINK_DIV(BlinkA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  score_display #(.SCAN_DIV(ScanB), .BLINK_DIV(BlinkB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int ct;
    int co;
    int ht;
    int ho;
    int cycle;
  } upd_t;

  upd_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per rising edge.
  int cyc       = 0;
  int busy_left = 0;
  int sh_c = 0, sh_h = 0;
  int p_ct = 0, p_co = 0, p_ht = 0, p_ho = 0;
  int m_ct = 0, m_co = 0, m_ht = 0, m_ho = 0;
  bit m_upd = 1'b0;
  int scan_div[2]  = '{ScanA, ScanB};
  int blink_div[2] = '{BlinkA, BlinkB};
  int scan_cnt[2]  = '{0, 0};
  int scan_idx[2]  = '{0, 0};
  int blink_cnt[2] = '{0, 0};
  bit blink_on[2]  = '{1'b1, 1'b1};

  function automatic logic [6:0] enc(int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int idx, bit on);
    case (idx)
      0: return on ? enc(m_co) : 7'h00;
      1: return (on && m_ct != 0) ? enc(m_ct) : 7'h00;
      2: return enc(m_ho);
      default: return (m_ht != 0) ? enc(m_ht) : 7'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        busy_left = 0;
        sh_c = 0; sh_h = 0;
        m_ct = 0; m_co = 0; m_ht = 0; m_ho = 0;
        m_upd = 1'b0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
          scan_cnt[i] = 0; scan_idx[i] = 0; blink_cnt[i] = 0; blink_on[i] = 1'b1;
        end
      end else begin
        m_upd = 1'b0;
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            m_ct = p_ct; m_co = p_co; m_ht = p_ht; m_ho = p_ho;
            m_upd = 1'b1;
          end
        end else if (int'(cs) != sh_c || int'(hs) != sh_h) begin
          upd_t u;
          int vc, vh;
          sh_c = int'(cs);
          sh_h = int'(hs);
          vc = (sh_c > 99) ? 99 : sh_c;
          vh = (sh_h > 99) ? 99 : sh_h;
          p_ct = vc / 10; p_co = vc % 10; p_ht = vh / 10; p_ho = vh % 10;
          busy_left = 8;
          u.ct = p_ct; u.co = p_co; u.ht = p_ht; u.ho = p_ho; u.cycle = cyc + 8;
          sb.push_back(u);
        end
        for (int i = 0; i < 2; i++) begin
          if (scan_cnt[i] == scan_div[i] - 1) begin
            scan_cnt[i] = 0;
            scan_idx[i] = (scan_idx[i] + 1) % 4;
          end else begin
            scan_cnt[i]++;
          end
          if (!igc) begin
            blink_cnt[i] = 0;
            blink_on[i]  = 1'b1;
          end else if (blink_cnt[i] == blink_div[i] - 1) begin
            blink_cnt[i] = 0;
            blink_on[i]  = !blink_on[i];
          end else begin
            blink_cnt[i]++;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs to the model and drains the scoreboard on each update.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("busy_a", bus_a.busy, busy_left > 0);
        check("busy_b", bus_b.busy, busy_left > 0);
        check("updated_a", bus_a.updated, m_upd);
        check("updated_b", bus_b.updated, m_upd);
        check("digits_a", {bus_a.currTens, bus_a.currOnes, bus_a.highTens, bus_a.highOnes},
              {m_ct[3:0], m_co[3:0], m_ht[3:0], m_ho[3:0]});
        check("digits_b", {bus_b.currTens, bus_b.currOnes, bus_b.highTens, bus_b.highOnes},
              {m_ct[3:0], m_co[3:0], m_ht[3:0], m_ho[3:0]});
        check("digitsel_a", bus_a.digitSel, 4'b0001 << scan_idx[0]);
        check("digitsel_b", bus_b.digitSel, 4'b0001 << scan_idx[1]);
        check("seg_a", bus_a.seg, exp_seg(scan_idx[0], blink_on[0]));
        check("seg_b", bus_b.seg, exp_seg(scan_idx[1], blink_on[1]));
        if (bus_a.updated === 1'b1) begin
          check("update_queued", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            upd_t u;
            u = sb.pop_front();
            check("upd_latency", cyc, u.cycle);
            check("upd_curr", {bus_a.currTens, bus_a.currOnes}, {u.ct[3:0], u.co[3:0]});
            check("upd_high", {bus_a.highTens, bus_a.highOnes}, {u.ht[3:0], u.ho[3:0]});
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    cs = 7'd4;   hs = 7'd4;   tick(12);
    cs = 7'd57;  hs = 7'd99;  tick(12);
    cs = 7'd120; hs = 7'd127; tick(20);
    cs = 7'd12;
    tick(4);
    cs = 7'd34;
    tick(25);
    igc = 1'b1; cs = 7'd77; hs = 7'd88;
    tick(40);
    igc = 1'b0;
    tick(4);
    cs = 7'd45;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(15);
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 8 == 0) cs = 7'($urandom_range(0, 127));
      if ($urandom % 8 == 0) hs = 7'($urandom_range(0, 127));
      if ($urandom % 20 == 0) igc = ~igc;
      rst = ($urandom % 97 == 0);
      tick(1);
    end
    rst = 1'b0;
    igc = 1'b0;
    tick(25);
    check("queue_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter SCAN_DIV, default 1024, clock cycles each digit is driven before the scan advances (minimum 1).
REQ-002 Parameter BLINK_DIV, default 16384, clock cycles per blink half-period while the game is complete (minimum 1).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 currScore  input  7  current score from the score tracker, unsigned.
REQ-006 highScore  input  7  high score from the score tracker, unsigned.
REQ-007 isGameComplete  input  1  game-over level from the score tracker.
REQ-008 currTens, currOnes, highTens, highOnes  output  4 each  registered BCD digits of the last converted scores.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 updated  output  1  one-cycle pulse when the digit outputs take new values.
REQ-011 seg  output  7  {g,f,e,d,c,b,a}, active-high, pattern for the selected digit.
REQ-012 digitSel  output  4  one-hot, active-high; bit0 currOnes, bit1 currTens, bit2 highOnes, bit3 highTens.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, when currScore or highScore differs from its shadow register, the block SHALL capture both inputs (capture edge E0), load the shadows with the raw inputs, clear a 3-bit shift count, and enter SHIFT.
REQ-015 At capture, any value above 99 SHALL be clamped to 99 in the conversion operand, but the shadow stores the raw value.
REQ-016 Each SHIFT cycle SHALL add 3 to every BCD nibble of value 5 or more, then shift the operand left by one bit into the BCD register. Both scores convert in parallel.
REQ-017 After 7 shifts (edges E1..E7) the FSM SHALL enter DONE.
REQ-018 DONE SHALL write all four digit outputs and assert updated at edge E8, then return to IDLE. Latency is 8 cycles from the capture edge.
REQ-019 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-020 Input changes during SHIFT or DONE SHALL be ignored for the active conversion. On return to IDLE, the shadow comparison SHALL start a new conversion on the next edge if the inputs still differ.
REQ-021 Digit outputs SHALL hold their values between updates.
REQ-022 A free-running scan counter SHALL rotate digitSel bit0 -> bit1 -> bit2 -> bit3 -> bit0 every SCAN_DIV cycles. digitSel is always exactly one-hot.
REQ-023 seg encoding for digits 0-9: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F. Blank is 0x00.
REQ-024 Leading-zero blanking: a tens digit equal to 0 SHALL display blank; ones digits always display.
REQ-025 While isGameComplete is high, a blink phase SHALL toggle every BLINK_DIV cycles. The current-score digits SHALL be blank in the off phase; high-score digits stay steady.
REQ-026 While isGameComplete is low, the blink phase SHALL be held in the on (visible) state and its counter cleared.
REQ-027 seg and digitSel SHALL be registered and change on the same edge.

Reset
REQ-028 With rst high at a rising edge:
- state IDLE; shadows, BCD registers and all digit outputs 0;
- busy 0, updated 0;
- scan and blink counters 0, blink phase on;
- digitSel 0001, seg 0x3F.
REQ-029 Reset SHALL take priority over every other action, including mid-conversion, and SHALL suppress any pending updated pulse.

Verification
REQ-030 Reset, all inputs 0 held 20 cycles -> digits 0, busy 0, updated never asserted, digitSel 0001, seg 0x3F.
REQ-031 currScore=4 and highScore=4 applied together -> busy high E1..E8, updated pulse at E8, currOnes=4, currTens=0; seg blank when digitSel=0010.
REQ-032 currScore=57, highScore=99 -> currTens/currOnes 5/7, highTens/highOnes 9/9; seg 0x6D while digitSel=0010.
REQ-033 currScore=120, highScore=127 -> all digits 9/9; after one update, no further conversion while the inputs hold.
REQ-034 currScore=12, then 34 at E3 -> first updated shows 1/2, second conversion starts 1 cycle after DONE, second updated shows 3/4.
REQ-035 isGameComplete high with BLINK_DIV=8 and SCAN_DIV=1 -> current-score digits blank in alternating 8-cycle windows, high digits unchanged. rst at E4 of a conversion -> IDLE next edge, no updated pulse, digits 0.
